// File: rtl/rpn_calc_param.sv
// Parametrised RPN calculator: valid/ready operand/operator stream in, results/errors out.
// Define RPN_DIV_EN to turn opcode 000 into an unsigned divide (otherwise it is a nop).
module rpn_calc_param #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_is_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_err,
    output logic [CNT_W-1:0] depth_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] E_OK  = 2'b00;
    localparam logic [1:0] E_UND = 2'b01;
    localparam logic [1:0] E_OVF = 2'b10;
`ifdef RPN_DIV_EN
    localparam logic [1:0] E_DZ  = 2'b11;
`endif

    typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] stk [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_err_q, out_err_d;

    logic             we_a, we_b;
    logic [AW-1:0]    idx_a, idx_b;
    logic [WIDTH-1:0] dat_a, dat_b;
    logic [AW-1:0]    top_idx, below_idx, nxt_idx;
    logic [WIDTH-1:0] r_val, l_val, alu;
    logic             empty, lt2, full;
    logic             err;
    logic [1:0]       err_code;

    assign top_idx   = AW'(cnt_q - CNT_W'(1));
    assign below_idx = AW'(cnt_q - CNT_W'(2));
    assign nxt_idx   = AW'(cnt_q);
    assign r_val     = stk[top_idx];
    assign l_val     = stk[below_idx];
    assign empty     = (cnt_q == '0);
    assign lt2       = (cnt_q < CNT_W'(2));
    assign full      = (cnt_q == CNT_W'(DEPTH));

    always_comb begin
        alu = '0;
        case (op_q)
            3'b001:  alu = l_val * r_val;
            3'b010:  alu = l_val + r_val;
            3'b011:  alu = l_val - r_val;
`ifdef RPN_DIV_EN
            3'b000:  alu = (r_val == '0) ? '0 : l_val / r_val;
`endif
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        we_a       = 1'b0;
        we_b       = 1'b0;
        idx_a      = nxt_idx;
        idx_b      = top_idx;
        dat_a      = in_data;
        dat_b      = l_val;
        err        = 1'b0;
        err_code   = E_OK;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_is_op) begin
                    op_d    = in_data[2:0];
                    state_d = EXEC;
                end else if (in_valid) begin
                    if (full) begin
                        err      = 1'b1;
                        err_code = E_OVF;
                    end else begin
                        we_a  = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            EXEC: begin
                state_d = IDLE;
                unique case (op_q)
                    3'b001, 3'b010, 3'b011: begin
                        if (lt2) begin
                            err      = 1'b1;
                            err_code = E_UND;
                        end else begin
                            we_a  = 1'b1;
                            idx_a = below_idx;
                            dat_a = alu;
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    3'b100: begin
                        if (empty) begin
                            err      = 1'b1;
                            err_code = E_UND;
                        end else begin
                            out_data_d = r_val;
                            out_err_d  = E_OK;
                            cnt_d      = cnt_q - CNT_W'(1);
                            state_d    = OUT;
                        end
                    end
                    3'b101: begin
                        if (empty) begin
                            err      = 1'b1;
                            err_code = E_UND;
                        end else if (full) begin
                            err      = 1'b1;
                            err_code = E_OVF;
                        end else begin
                            we_a  = 1'b1;
                            dat_a = r_val;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    3'b110: begin
                        if (lt2) begin
                            err      = 1'b1;
                            err_code = E_UND;
                        end else begin
                            we_a  = 1'b1;
                            idx_a = below_idx;
                            dat_a = r_val;
                            we_b  = 1'b1;
                        end
                    end
                    3'b111: cnt_d = '0;
                    3'b000: begin
`ifdef RPN_DIV_EN
                        if (lt2) begin
                            err      = 1'b1;
                            err_code = E_UND;
                        end else if (r_val == '0) begin
                            err      = 1'b1;
                            err_code = E_DZ;
                        end else begin
                            we_a  = 1'b1;
                            idx_a = below_idx;
                            dat_a = alu;
                            cnt_d = cnt_q - CNT_W'(1);
                        end
`endif
                    end
                endcase
            end
            OUT: begin
                if (out_ready) begin
                    out_data_d = '0;
                    out_err_d  = E_OK;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // errors leave the stack untouched and report a zero result
        if (err) begin
            we_a       = 1'b0;
            we_b       = 1'b0;
            cnt_d      = cnt_q;
            out_data_d = '0;
            out_err_d  = err_code;
            state_d    = OUT;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            out_data_q <= '0;
            out_err_q  <= E_OK;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (we_a) stk[idx_a] <= dat_a;
        if (we_b) stk[idx_b] <= dat_b;
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == OUT);
    assign out_data    = out_data_q;
    assign out_err     = out_err_q;
    assign depth_count = cnt_q;

endmodule
